// File: rtl/pong_pkg.sv
// rtl/pong_pkg.sv - shared types and constants for the pong paddle controller
package pong_pkg;

  typedef enum logic [1:0] {
    MODE_Y    = 2'd0,
    MODE_X    = 2'd1,
    MODE_INVX = 2'd2
  } paddle_mode_t;

  typedef enum logic {
    ST_ANALOG  = 1'b0,
    ST_DIGITAL = 1'b1
  } chan_state_t;

  localparam int JOY_R = 0;
  localparam int JOY_L = 1;
  localparam int JOY_D = 2;
  localparam int JOY_U = 3;

  localparam logic [7:0] PADDLE_CENTER = 8'h80;

  // Encoding 3 is not a real mode; it falls back to the Y axis.
  function automatic paddle_mode_t decode_mode(input logic [1:0] m);
    case (m)
      2'd1:    return MODE_X;
      2'd2:    return MODE_INVX;
      default: return MODE_Y;
    endcase
  endfunction

endpackage

// File: rtl/paddle_chan.sv
// rtl/paddle_chan.sv - one player's analog/digital paddle arbiter and position accumulator
import pong_pkg::*;

module paddle_chan #(
  parameter int STEP         = 4,
  parameter int ACCEL_FRAMES = 15,
  parameter int DEADZONE     = 12
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        tick,
  input  logic [1:0]  mode,
  input  logic [15:0] analog,
  input  logic [3:0]  joy,
  output logic [7:0]  vpos,
  output logic        src
);

  localparam int HW = $clog2(ACCEL_FRAMES + 1);
  localparam logic [HW-1:0] HOLD_MAX = HW'(ACCEL_FRAMES);
  localparam logic [8:0] STEP_LO = 9'(STEP);
  localparam logic [8:0] STEP_HI = 9'(2 * STEP);
  localparam logic [8:0] DZ      = 9'(DEADZONE);

  chan_state_t   state, state_n;
  paddle_mode_t  pmode;
  logic [7:0]    vpos_n, anchor, anchor_n, amap, stepped;
  logic [HW-1:0] hold, hold_n, hold_eff, hold_inc;
  logic [1:0]    mode_q, mode_q_n;
  logic          dir_q, dir_q_n, inc, dec, move;
  logic [8:0]    step, sum, diff, dev;

  always_comb begin
    pmode = decode_mode(mode);
    amap  = analog[15:8] + 8'h80;
    inc   = joy[JOY_D];
    dec   = joy[JOY_U];
    case (pmode)
      MODE_X: begin
        amap = analog[7:0] + 8'h80;
        inc  = joy[JOY_R];
        dec  = joy[JOY_L];
      end
      MODE_INVX: begin
        amap = analog[7:0] ^ 8'h7F;
        inc  = joy[JOY_L];
        dec  = joy[JOY_R];
      end
      default: ;
    endcase
  end

  // hold is zero after any idle tick, so dir_q only matters while a press continues.
  assign move     = inc ^ dec;
  assign hold_eff = (dir_q == inc) ? hold : '0;
  assign step     = (hold_eff == HOLD_MAX) ? STEP_HI : STEP_LO;
  assign hold_inc = (hold_eff == HOLD_MAX) ? HOLD_MAX : hold_eff + 1'b1;
  assign sum      = {1'b0, vpos} + step;
  assign diff     = {1'b0, vpos} - step;
  assign dev      = (amap >= anchor) ? ({1'b0, amap} - {1'b0, anchor})
                                     : ({1'b0, anchor} - {1'b0, amap});

  always_comb begin
    stepped = 8'h00;
    if (inc) stepped = sum[8] ? 8'hFF : sum[7:0];
    else     stepped = ({1'b0, vpos} < step) ? 8'h00 : diff[7:0];
  end

  always_comb begin
    state_n  = state;
    vpos_n   = vpos;
    anchor_n = anchor;
    hold_n   = hold;
    mode_q_n = mode_q;
    dir_q_n  = dir_q;
    if (tick) begin
      mode_q_n = mode;
      if (mode != mode_q) begin
        state_n = ST_ANALOG;
        vpos_n  = amap;
        hold_n  = '0;
      end else if (move) begin
        state_n  = ST_DIGITAL;
        vpos_n   = stepped;
        anchor_n = amap;
        hold_n   = hold_inc;
        dir_q_n  = inc;
      end else begin
        hold_n = '0;
        if (state == ST_ANALOG) begin
          vpos_n = amap;
        end else if (dev > DZ) begin
          state_n = ST_ANALOG;
          vpos_n  = amap;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state  <= ST_ANALOG;
      vpos   <= PADDLE_CENTER;
      anchor <= PADDLE_CENTER;
      hold   <= '0;
      mode_q <= 2'd0;
      dir_q  <= 1'b0;
    end else begin
      state  <= state_n;
      vpos   <= vpos_n;
      anchor <= anchor_n;
      hold   <= hold_n;
      mode_q <= mode_q_n;
      dir_q  <= dir_q_n;
    end
  end

  assign src = (state == ST_DIGITAL);

endmodule

// File: rtl/paddle_ctrl.sv
// rtl/paddle_ctrl.sv - frame-tick generator and two independent paddle channels
import pong_pkg::*;

module paddle_ctrl #(
  parameter int STEP         = 4,
  parameter int ACCEL_FRAMES = 15,
  parameter int DEADZONE     = 12
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic        vblank,
  input  logic [1:0]  mode1,
  input  logic [1:0]  mode2,
  input  logic [15:0] analog1,
  input  logic [15:0] analog2,
  input  logic [3:0]  joy1,
  input  logic [3:0]  joy2,
  output logic [7:0]  paddle1_vpos,
  output logic [7:0]  paddle2_vpos,
  output logic        src1,
  output logic        src2
);

  logic vblank_q;
  logic tick;

  // Resetting to 1 suppresses a spurious tick when reset releases inside vblank.
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) vblank_q <= 1'b1;
    else       vblank_q <= vblank;
  end

  assign tick = vblank & ~vblank_q;

  paddle_chan #(.STEP(STEP), .ACCEL_FRAMES(ACCEL_FRAMES), .DEADZONE(DEADZONE)) u_chan1 (
    .clk    (clk_sys),
    .reset  (reset),
    .tick   (tick),
    .mode   (mode1),
    .analog (analog1),
    .joy    (joy1),
    .vpos   (paddle1_vpos),
    .src    (src1)
  );

  paddle_chan #(.STEP(STEP), .ACCEL_FRAMES(ACCEL_FRAMES), .DEADZONE(DEADZONE)) u_chan2 (
    .clk    (clk_sys),
    .reset  (reset),
    .tick   (tick),
    .mode   (mode2),
    .analog (analog2),
    .joy    (joy2),
    .vpos   (paddle2_vpos),
    .src    (src2)
  );

endmodule

// File: tb/tb_paddle_ctrl.sv
// tb/tb_paddle_ctrl.sv - table-driven scoreboard bench for paddle_ctrl
module tb_paddle_ctrl;

  typedef struct {
    logic [1:0]  mode;
    logic [15:0] analog;
    logic [3:0]  joy;
    logic [7:0]  x2;
    logic [7:0]  exp_vpos;
    logic        exp_src;
  } vec_t;

  typedef struct {
    logic [7:0] vpos1;
    logic       src1;
    logic [7:0] vpos2;
    logic       src2;
  } exp_t;

  logic        clk_sys = 1'b0;
  logic        reset   = 1'b1;
  logic        vblank  = 1'b0;
  logic [1:0]  mode1 = 2'd0, mode2 = 2'd1;
  logic [15:0] analog1 = 16'h0000, analog2 = 16'h0000;
  logic [3:0]  joy1 = 4'h0, joy2 = 4'h0;
  logic [7:0]  paddle1_vpos, paddle2_vpos;
  logic        src1, src2;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   x2_cnt   = 0;
  vec_t vecs[$];
  exp_t sb[$];

  paddle_ctrl dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .vblank       (vblank),
    .mode1        (mode1),
    .mode2        (mode2),
    .analog1      (analog1),
    .analog2      (analog2),
    .joy1         (joy1),
    .joy2         (joy2),
    .paddle1_vpos (paddle1_vpos),
    .paddle2_vpos (paddle2_vpos),
    .src1         (src1),
    .src2         (src2)
  );

  always #5 clk_sys = ~clk_sys;

  task automatic check(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic add_vec(input logic [1:0] m, input logic [15:0] a, input logic [3:0] j,
                         input logic [7:0] ev, input logic es);
    vec_t v;
    v.mode = m; v.analog = a; v.joy = j;
    v.x2 = 8'(x2_cnt * 37 + 5);
    v.exp_vpos = ev; v.exp_src = es;
    x2_cnt++;
    vecs.push_back(v);
  endtask

  // Channel 2 stays in X mode with the Y-axis D-pad pressed, which X mode must ignore.
  task automatic run_frame(input vec_t v, input string name);
    exp_t e;
    @(negedge clk_sys);
    mode1 = v.mode; analog1 = v.analog; joy1 = v.joy;
    mode2 = 2'd1;   analog2 = {8'h55, v.x2}; joy2 = 4'b0100;
    sb.push_back('{v.exp_vpos, v.exp_src, 8'(v.x2 + 8'h80), 1'b0});
    vblank = 1'b1;
    @(negedge clk_sys);
    if (sb.size() == 0) begin
      n_checks++; n_fail++;
      $display("FAIL %s: scoreboard empty", name);
    end else begin
      e = sb.pop_front();
      check({name, " vpos1"}, paddle1_vpos, e.vpos1);
      check({name, " src1"}, {7'd0, src1}, {7'd0, e.src1});
      check({name, " vpos2"}, paddle2_vpos, e.vpos2);
      check({name, " src2"}, {7'd0, src2}, {7'd0, e.src2});
    end
    vblank = 1'b0;
    @(negedge clk_sys);
  endtask

  initial begin
    vec_t v;

    add_vec(2'd0, 16'h0000, 4'h0, 8'h80, 1'b0);
    add_vec(2'd2, 16'h0010, 4'h0, 8'h6F, 1'b0);
    add_vec(2'd1, 16'h0010, 4'h0, 8'h90, 1'b0);
    add_vec(2'd1, 16'h00F0, 4'h0, 8'h70, 1'b0);
    add_vec(2'd0, 16'h7F00, 4'h0, 8'hFF, 1'b0);
    add_vec(2'd0, 16'h8000, 4'h0, 8'h00, 1'b0);
    add_vec(2'd3, 16'h1000, 4'h0, 8'h90, 1'b0);
    add_vec(2'd0, 16'h0000, 4'h0, 8'h80, 1'b0);
    for (int i = 0; i < 20; i++)
      add_vec(2'd0, 16'h0000, 4'b0100,
              (i < 15) ? 8'(8'h80 + 4 * (i + 1)) : 8'(8'h80 + 60 + 8 * (i - 14)), 1'b1);
    add_vec(2'd0, 16'h0C00, 4'h0, 8'hE4, 1'b1);
    add_vec(2'd0, 16'h0D00, 4'h0, 8'h8D, 1'b0);
    add_vec(2'd0, 16'h8200, 4'h0, 8'h02, 1'b0);
    add_vec(2'd0, 16'h8200, 4'b1000, 8'h00, 1'b1);
    add_vec(2'd0, 16'h8200, 4'b1000, 8'h00, 1'b1);
    add_vec(2'd0, 16'h8200, 4'b1100, 8'h00, 1'b1);
    for (int i = 0; i < 15; i++)
      add_vec(2'd0, 16'h8200, 4'b0100, 8'(4 * (i + 1)), 1'b1);
    add_vec(2'd0, 16'h8200, 4'b1100, 8'h3C, 1'b1);
    add_vec(2'd0, 16'h8200, 4'b0100, 8'h40, 1'b1);
    add_vec(2'd0, 16'h7E00, 4'h0, 8'hFE, 1'b0);
    add_vec(2'd0, 16'h7E00, 4'b0100, 8'hFF, 1'b1);
    add_vec(2'd0, 16'h7E00, 4'b0100, 8'hFF, 1'b1);
    add_vec(2'd0, 16'h0000, 4'h0, 8'h80, 1'b0);
    add_vec(2'd0, 16'h0000, 4'b0100, 8'h84, 1'b1);
    add_vec(2'd0, 16'h0000, 4'b0100, 8'h88, 1'b1);

    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    repeat (2) @(negedge clk_sys);
    check("reset vpos1", paddle1_vpos, 8'h80);
    check("reset src1", {7'd0, src1}, 8'h00);
    check("reset vpos2", paddle2_vpos, 8'h80);

    for (int i = 0; i < vecs.size(); i++) begin
      v = vecs[i];
      run_frame(v, $sformatf("vec%0d", i));
    end

    @(negedge clk_sys);
    joy1 = 4'b1000; analog1 = 16'h7000;
    repeat (6) @(negedge clk_sys);
    check("between ticks vpos1", paddle1_vpos, 8'h88);
    check("between ticks src1", {7'd0, src1}, 8'h01);

    joy1 = 4'b0100; analog1 = 16'h0000;
    @(negedge clk_sys);
    reset = 1'b1;
    #1;
    check("async reset vpos1", paddle1_vpos, 8'h80);
    check("async reset src1", {7'd0, src1}, 8'h00);
    check("async reset vpos2", paddle2_vpos, 8'h80);
    @(negedge clk_sys);
    vblank = 1'b1;
    @(negedge clk_sys);
    reset = 1'b0;
    repeat (5) @(negedge clk_sys);
    check("release in vblank vpos1", paddle1_vpos, 8'h80);
    check("release in vblank src1", {7'd0, src1}, 8'h00);
    vblank = 1'b0;
    @(negedge clk_sys);
    v.mode = 2'd0; v.analog = 16'h0000; v.joy = 4'b0100; v.x2 = 8'h33;
    v.exp_vpos = 8'h84; v.exp_src = 1'b1;
    run_frame(v, "after reset");

    if (sb.size() != 0) begin
      n_checks++; n_fail++;
      $display("FAIL scoreboard leftover: got %0d expected 0", sb.size());
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
